mult_div_unit: RTL and testbench

Sequential signed multiply/divide engine for the multicycle MIPS datapath, sitting directly downstream of the control unit. It consumes the control unit's mult_start, div_start and mult_or_div, and operands from the A/B registers. It produces 64-bit results on hi_out/lo_out, which the control unit commits to the architectural HI/LO registers via hi_write/lo_write. It raises div_zero back to the control unit for exception handling.

---
 rtl/mips_pkg.sv | 18 +
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: multiply/divide FSM
// encoding, iteration count and HI/LO output-select codes.
package mips_pkg;

   localparam int MD_WIDTH      = 32;
   localparam int MD_ITERATIONS = MD_WIDTH;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MULT,
      MD_DIV,
      MD_FINISH
   } md_state_e;

   localparam logic MD_SEL_MULT = 1'b0;
   localparam logic MD_SEL_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide engine bundle: operands, start strobes,
// result select, and the HI/LO results with status.
interface mult_div_unit_if #(
   parameter int WIDTH = mips_pkg::MD_WIDTH
);

   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             mult_start;
   logic             div_start;
   logic             mult_or_div;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output a_in, b_in, mult_start, div_start, mult_or_div,
      input  hi_out, lo_out, busy, done, div_zero
   );

   modport slave (
      input  a_in, b_in, mult_start, div_start, mult_or_div,
      output hi_out, lo_out, busy, done, div_zero
   );

endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (shift-add) / divide (restoring) engine, one bit
// per clock on operand magnitudes, with separately held mult and div result pairs.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = MD_ITERATIONS
) (
   input  logic           clock,
   input  logic           reset,
   mult_div_unit_if.slave md
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;        // product accumulator; low half doubles as dividend/quotient
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               neg_q, neg_d;        // product / quotient sign
   logic               rneg_q, rneg_d;      // remainder follows the dividend
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   mul_hi_q, mul_hi_d, mul_lo_q, mul_lo_d;
   logic [WIDTH-1:0]   div_hi_q, div_hi_d, div_lo_q, div_lo_d;

   logic [WIDTH:0]     madd;
   logic [2*WIDTH-1:0] acc_mul;
   logic [WIDTH:0]     shifted;
   logic               fits;
   logic [WIDTH-1:0]   rem_div, quo_div;

   // Two's-complement magnitude; the most negative value maps to its unsigned twin.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign madd    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign acc_mul = {madd, acc_q[WIDTH-1:1]};
   assign shifted = {rem_q, acc_q[WIDTH-1]};
   assign fits    = shifted >= {1'b0, opnd_q};
   assign rem_div = fits ? WIDTH'(shifted - {1'b0, opnd_q}) : shifted[WIDTH-1:0];
   assign quo_div = {acc_q[WIDTH-2:0], fits};

   always_comb begin
      // NOTE: every next-state signal defaults to its current value first, so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      mul_hi_d = mul_hi_q;
      mul_lo_d = mul_lo_q;
      div_hi_d = div_hi_q;
      div_lo_d = div_lo_q;

      unique case (state_q)
         MD_IDLE: begin
            if (md.mult_start || md.div_start) begin
               cnt_d  = '0;
               rem_d  = '0;
               neg_d  = md.a_in[WIDTH-1] ^ md.b_in[WIDTH-1];
               rneg_d = md.a_in[WIDTH-1];
               dz_d   = 1'b0;
               if (md.mult_start) begin
                  state_d = MD_MULT;
                  opnd_d  = abs_val(md.a_in);
                  acc_d   = {{WIDTH{1'b0}}, abs_val(md.b_in)};
               end else begin
                  opnd_d = abs_val(md.b_in);
                  acc_d  = {{WIDTH{1'b0}}, abs_val(md.a_in)};
                  if (md.b_in == '0) begin
                     dz_d    = 1'b1;
                     state_d = MD_FINISH;
                  end else begin
                     state_d = MD_DIV;
                  end
               end
            end
         end
         MD_MULT: begin
            acc_d = acc_mul;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d              = MD_FINISH;
               {mul_hi_d, mul_lo_d} = neg_q ? -acc_mul : acc_mul;
            end
         end
         MD_DIV: begin
            acc_d[WIDTH-1:0] = quo_div;
            rem_d            = rem_div;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d  = MD_FINISH;
               div_lo_d = neg_q  ? -quo_div : quo_div;
               div_hi_d = rneg_q ? -rem_div : rem_div;
            end
         end
         MD_FINISH: state_d = MD_IDLE;
         default:   state_d = MD_IDLE;
      endcase
   end

   // NOTE: result pairs are reset too, because hi_out/lo_out must read zero straight out of reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         mul_hi_q <= '0;
         mul_lo_q <= '0;
         div_hi_q <= '0;
         div_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         mul_hi_q <= mul_hi_d;
         mul_lo_q <= mul_lo_d;
         div_hi_q <= div_hi_d;
         div_lo_q <= div_lo_d;
      end
   end

   assign md.busy     = (state_q != MD_IDLE);
   assign md.done     = (state_q == MD_FINISH);
   assign md.div_zero = dz_q;
   assign md.hi_out   = (md.mult_or_div == MD_SEL_DIV) ? div_hi_q : mul_hi_q;
   assign md.lo_out   = (md.mult_or_div == MD_SEL_DIV) ? div_lo_q : mul_lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a signed-arithmetic reference model.
module tb_mult_div_unit;
   import mips_pkg::*;

   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;

   mult_div_unit_if #(.WIDTH(W)) md_if();

   mult_div_unit #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .md    (md_if.slave)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: the two held result pairs and the sticky flag.
   logic [W-1:0] exp_mhi = '0, exp_mlo = '0, exp_dhi = '0, exp_dlo = '0;
   logic         exp_dz  = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ms, input logic ds, output int lat);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lat = W;
      if (ms) begin
         p = sa * sb;
         {exp_mhi, exp_mlo} = p;
         exp_dz = 1'b0;
      end else if (ds) begin
         if (b == '0) begin
            exp_dz = 1'b1;
            lat    = 0;
         end else begin
            exp_dlo = W'(sa / sb);
            exp_dhi = W'(sa % sb);
            exp_dz  = 1'b0;
         end
      end
   endtask

   task automatic check_results(input string tag);
      md_if.mult_or_div = MD_SEL_MULT;
      #1;
      check({tag, " mult hi"}, md_if.hi_out, exp_mhi);
      check({tag, " mult lo"}, md_if.lo_out, exp_mlo);
      md_if.mult_or_div = MD_SEL_DIV;
      #1;
      check({tag, " div hi"}, md_if.hi_out, exp_dhi);
      check({tag, " div lo"}, md_if.lo_out, exp_dlo);
      check({tag, " div_zero"}, md_if.div_zero, exp_dz);
   endtask

   task automatic check_pair(input string tag, input logic sel,
                             input logic [W-1:0] hi, input logic [W-1:0] lo);
      md_if.mult_or_div = sel;
      #1;
      check({tag, " hi"}, md_if.hi_out, hi);
      check({tag, " lo"}, md_if.lo_out, lo);
   endtask

   // One operation: start at edge N, optional stray start pulse at iteration glitch_at.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ms, input logic ds, input int glitch_at);
      int lat;
      int cyc;
      @(negedge clock);
      md_if.a_in       = a;
      md_if.b_in       = b;
      md_if.mult_start = ms;
      md_if.div_start  = ds;
      model(a, b, ms, ds, lat);
      @(negedge clock);
      md_if.mult_start = 1'b0;
      md_if.div_start  = 1'b0;
      md_if.a_in       = $urandom;
      md_if.b_in       = $urandom;
      check({tag, " busy@N"}, md_if.busy, 1'b1);
      check({tag, " div_zero@N"}, md_if.div_zero, exp_dz);
      cyc = 0;
      while (!md_if.done && cyc < 100) begin
         md_if.mult_start = (cyc == glitch_at);
         md_if.div_start  = (cyc == glitch_at);
         @(negedge clock);
         cyc++;
      end
      md_if.mult_start = 1'b0;
      md_if.div_start  = 1'b0;
      check({tag, " latency"}, cyc, lat);
      check({tag, " busy@done"}, md_if.busy, 1'b1);
      @(negedge clock);
      check({tag, " done cleared"}, md_if.done, 1'b0);
      check({tag, " busy cleared"}, md_if.busy, 1'b0);
      check_results(tag);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      bit saw_done;
      md_if.a_in        = '0;
      md_if.b_in        = '0;
      md_if.mult_start  = 1'b0;
      md_if.div_start   = 1'b0;
      md_if.mult_or_div = MD_SEL_MULT;
      reset             = 1'b1;
      #12;
      check("reset busy", md_if.busy, 1'b0);
      check("reset done", md_if.done, 1'b0);
      check_results("reset");
      @(negedge clock);
      reset = 1'b0;

      run_op("mul 7*-3", 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, -1);
      check_pair("mul 7*-3 const", MD_SEL_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, -1);
      check_pair("div 7/-2 const", MD_SEL_DIV, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, -1);
      check_pair("div -7/2 const", MD_SEL_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("mul min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, -1);
      check_pair("mul min*min const", MD_SEL_MULT, 32'h4000_0000, 32'h0000_0000);
      run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, -1);
      check_pair("div min/-1 const", MD_SEL_DIV, 32'h0000_0000, 32'h8000_0000);

      run_op("div 7/2", 32'd7, 32'd2, 1'b0, 1'b1, -1);
      run_op("div 5/0", 32'd5, 32'd0, 1'b0, 1'b1, -1);
      check_pair("div 5/0 kept", MD_SEL_DIV, 32'd1, 32'd3);
      run_op("mul clears dz", 32'd3, 32'd5, 1'b1, 1'b0, -1);

      run_op("both starts", 32'd6, 32'd4, 1'b1, 1'b1, 10);
      check_pair("both starts const", MD_SEL_MULT, 32'd0, 32'd24);

      // Asynchronous reset in the middle of a multiply.
      @(negedge clock);
      md_if.a_in       = 32'd123;
      md_if.b_in       = 32'd456;
      md_if.mult_start = 1'b1;
      @(negedge clock);
      md_if.mult_start = 1'b0;
      repeat (15) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      exp_mhi = '0; exp_mlo = '0; exp_dhi = '0; exp_dlo = '0; exp_dz = 1'b0;
      check("abort busy", md_if.busy, 1'b0);
      check("abort done", md_if.done, 1'b0);
      check_results("abort");
      @(negedge clock);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (md_if.done) saw_done = 1'b1;
      end
      check("no done after abort", saw_done, 1'b0);
      run_op("after abort", 32'hFFFF_FFF0, 32'd9, 1'b1, 1'b0, -1);

      for (int i = 0; i < 25; i++) begin
         logic [W-1:0] a, b;
         logic ms, ds;
         int   sel;
         a   = pick_operand();
         b   = pick_operand();
         sel = $urandom_range(0, 3);
         ms  = (sel == 0) || (sel == 2);
         ds  = (sel != 0);
         run_op($sformatf("rand%0d", i), a, b, ms, ds,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
